// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 16x oversampling, 3-sample majority vote, optional parity, 1/2 stop bits.
// Define UART_RX_BREAK_DET_EN to compile in break detection and the BRK_WAIT re-arm state.
`timescale 1ns/1ps
module uart_rx_param #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int OS_DIV     = CLOCK_FREQ / (BAUD * OVERSAMPLE) - 1,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   input  logic                 uart_rx,
   output logic                 Rx_Done,
   output logic [DATA_BITS-1:0] Rx_Data,
   output logic                 Frame_Error,
   output logic                 Parity_Error,
   output logic                 Break_Det
);

   localparam int PW = (OS_DIV < 1) ? 1 : $clog2(OS_DIV + 1);
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [PW-1:0] PRESC_TC = PW'(OS_DIV);
   localparam logic [SW-1:0] SAMP_A   = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] SAMP_B   = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] SAMP_C   = SW'(OVERSAMPLE / 2 + 1);
   localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

`ifdef UART_RX_BREAK_DET_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK_WAIT} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
`endif

   state_t               state_q, state_d;
   logic                 sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
   logic [PW-1:0]        presc_q, presc_d;
   logic [SW-1:0]        scnt_q, scnt_d;
   logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
   logic                 stop_idx_q, stop_idx_d;
   logic                 s0_q, s0_d, s1_q, s1_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 ferr_q, ferr_d, perr_q, perr_d;
   logic                 rx_done_q, rx_done_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 frame_err_q, frame_err_d, parity_err_q, parity_err_d;
   logic                 tick, fall, samp_a, samp_b, decide, bit_end, vote, exp_par, final_stop;
`ifdef UART_RX_BREAK_DET_EN
   logic                 brk_q, brk_d, par_bit_q, par_bit_d, break_q, break_d;
   logic                 brk_now, brk_fin;
`endif

   assign tick       = (presc_q == PRESC_TC);
   assign fall       = !sync2_q && hist_q;
   assign samp_a     = tick && (scnt_q == SAMP_A);
   assign samp_b     = tick && (scnt_q == SAMP_B);
   assign decide     = tick && (scnt_q == SAMP_C);
   assign bit_end    = tick && (scnt_q == S_LAST);
   // Third sample is the live synchronised line, so the vote is ready on the deciding tick.
   assign vote       = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);
   assign exp_par    = (^shift_q) ^ (PARITY == 1);
   assign final_stop = (STOP_BITS == 1) || stop_idx_q;
`ifdef UART_RX_BREAK_DET_EN
   assign brk_now    = (shift_q == '0) && ((PARITY == 0) || !par_bit_q) && !vote;
   assign brk_fin    = stop_idx_q ? brk_q : brk_now;
`endif

   always_comb begin
      sync1_d      = uart_rx;
      sync2_d      = sync1_q;
      hist_d       = sync2_q;
      presc_d      = tick ? '0 : presc_q + PW'(1);
      state_d      = state_q;
      scnt_d       = scnt_q;
      bit_cnt_d    = bit_cnt_q;
      stop_idx_d   = stop_idx_q;
      s0_d         = samp_a ? sync2_q : s0_q;
      s1_d         = samp_b ? sync2_q : s1_q;
      shift_d      = shift_q;
      ferr_d       = ferr_q;
      perr_d       = perr_q;
      rx_done_d    = 1'b0;
      rx_data_d    = rx_data_q;
      frame_err_d  = frame_err_q;
      parity_err_d = parity_err_q;
`ifdef UART_RX_BREAK_DET_EN
      brk_d        = brk_q;
      par_bit_d    = par_bit_q;
      break_d      = 1'b0;
`endif
      if (tick && state_q != S_IDLE)
         scnt_d = bit_end ? '0 : scnt_q + SW'(1);

      case (state_q)
         S_IDLE: begin
            if (fall) begin
               state_d = S_START;
               presc_d = '0;
               scnt_d  = '0;
            end
         end
         S_START: begin
            if (decide && vote) begin
               state_d = S_IDLE;
            end else if (bit_end) begin
               state_d   = S_DATA;
               bit_cnt_d = '0;
               ferr_d    = 1'b0;
               perr_d    = 1'b0;
            end
         end
         S_DATA: begin
            if (decide)
               shift_d = {vote, shift_q[DATA_BITS-1:1]};
            if (bit_end) begin
               stop_idx_d = 1'b0;
               if (bit_cnt_q == LAST_BIT)
                  state_d = (PARITY != 0) ? S_PAR : S_STOP;
               else
                  bit_cnt_d = bit_cnt_q + BW'(1);
            end
         end
         S_PAR: begin
            if (decide) begin
               perr_d = (vote != exp_par);
`ifdef UART_RX_BREAK_DET_EN
               par_bit_d = vote;
`endif
            end
            if (bit_end)
               state_d = S_STOP;
         end
         S_STOP: begin
            if (decide) begin
               // Final stop decision completes the frame mid-bit so back-to-back frames are caught.
               if (final_stop) begin
                  rx_done_d    = 1'b1;
                  rx_data_d    = shift_q;
                  frame_err_d  = ferr_q | !vote;
                  parity_err_d = perr_q;
                  scnt_d       = '0;
`ifdef UART_RX_BREAK_DET_EN
                  break_d      = brk_fin;
                  state_d      = brk_fin ? S_BRK_WAIT : S_IDLE;
`else
                  state_d      = S_IDLE;
`endif
               end else begin
                  ferr_d = ferr_q | !vote;
`ifdef UART_RX_BREAK_DET_EN
                  brk_d  = brk_now;
`endif
               end
            end
            if (bit_end)
               stop_idx_d = 1'b1;
         end
`ifdef UART_RX_BREAK_DET_EN
         S_BRK_WAIT: begin
            // Re-arm only after a full bit time of continuous idle-high ticks.
            if (tick) begin
               if (!sync2_q) begin
                  scnt_d = '0;
               end else if (scnt_q == S_LAST) begin
                  state_d = S_IDLE;
                  scnt_d  = '0;
               end
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= S_IDLE;
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         hist_q       <= 1'b1;
         presc_q      <= '0;
         scnt_q       <= '0;
         bit_cnt_q    <= '0;
         stop_idx_q   <= 1'b0;
         s0_q         <= 1'b0;
         s1_q         <= 1'b0;
         shift_q      <= '0;
         ferr_q       <= 1'b0;
         perr_q       <= 1'b0;
         rx_done_q    <= 1'b0;
         rx_data_q    <= '0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         hist_q       <= hist_d;
         presc_q      <= presc_d;
         scnt_q       <= scnt_d;
         bit_cnt_q    <= bit_cnt_d;
         stop_idx_q   <= stop_idx_d;
         s0_q         <= s0_d;
         s1_q         <= s1_d;
         shift_q      <= shift_d;
         ferr_q       <= ferr_d;
         perr_q       <= perr_d;
         rx_done_q    <= rx_done_d;
         rx_data_q    <= rx_data_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
      end
   end

`ifdef UART_RX_BREAK_DET_EN
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         brk_q     <= 1'b0;
         par_bit_q <= 1'b0;
         break_q   <= 1'b0;
      end else begin
         brk_q     <= brk_d;
         par_bit_q <= par_bit_d;
         break_q   <= break_d;
      end
   end
   assign Break_Det = break_q;
`else
   assign Break_Det = 1'b0;
`endif

   assign Rx_Done      = rx_done_q;
   assign Rx_Data      = rx_data_q;
   assign Frame_Error  = frame_err_q;
   assign Parity_Error = parity_err_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: default 8N1 instance plus an even-parity and a 7-bit/2-stop instance.
`timescale 1ns/1ps
module tb_uart_rx_param;

   localparam int CLK_HZ   = 50_000_000;
   localparam int T0       = CLK_HZ / (115200 * 16);     // clocks per tick, default instance
   localparam int BIT0     = 16 * T0;
   localparam int LAT0     = (9 * 16 + 8 + 2) * T0 + 1;  // NB = 10
   localparam int FAST_BD  = 781250;
   localparam int TF       = CLK_HZ / (FAST_BD * 16);
   localparam int BITF     = 16 * TF;
`ifdef UART_RX_BREAK_DET_EN
   localparam int BRK_EN = 1;
`else
   localparam int BRK_EN = 0;
`endif

   typedef struct { int data; int fe; int pe; int brk; } exp_t;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
   logic       done0, fe0, pe0, brk0, done1, fe1, pe1, brk1, done2, fe2, pe2, brk2;
   logic [7:0] data0, data1;
   logic [6:0] data2;

   int   n_cmp = 0, n_err = 0;
   int   cyc = 0, t_fall = 0, last_done0 = 0;
   int   dcnt0 = 0, dcnt1 = 0, dcnt2 = 0;
   exp_t q0[$], q1[$], q2[$];

   uart_rx_param u0 (
      .Clk(Clk), .Reset_n(Reset_n), .uart_rx(rx0), .Rx_Done(done0), .Rx_Data(data0),
      .Frame_Error(fe0), .Parity_Error(pe0), .Break_Det(brk0));
   uart_rx_param #(.BAUD(FAST_BD), .PARITY(2)) u1 (
      .Clk(Clk), .Reset_n(Reset_n), .uart_rx(rx1), .Rx_Done(done1), .Rx_Data(data1),
      .Frame_Error(fe1), .Parity_Error(pe1), .Break_Det(brk1));
   uart_rx_param #(.BAUD(FAST_BD), .DATA_BITS(7), .STOP_BITS(2)) u2 (
      .Clk(Clk), .Reset_n(Reset_n), .uart_rx(rx2), .Rx_Done(done2), .Rx_Data(data2),
      .Frame_Error(fe2), .Parity_Error(pe2), .Break_Det(brk2));

   always #10 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge Clk) begin
      exp_t e;
      if (done0 === 1'b1) begin
         dcnt0++;
         last_done0 = cyc;
         check_val("u0_sb_nonempty", int'(q0.size() > 0), 1);
         if (q0.size() > 0) begin
            e = q0.pop_front();
            check_val("u0_data", int'(data0), e.data);
            check_val("u0_fe", int'(fe0), e.fe);
            check_val("u0_pe", int'(pe0), e.pe);
            check_val("u0_brk", int'(brk0), e.brk);
         end
      end
   end

   always @(negedge Clk) begin
      exp_t e;
      if (done1 === 1'b1) begin
         dcnt1++;
         check_val("u1_sb_nonempty", int'(q1.size() > 0), 1);
         if (q1.size() > 0) begin
            e = q1.pop_front();
            check_val("u1_data", int'(data1), e.data);
            check_val("u1_fe", int'(fe1), e.fe);
            check_val("u1_pe", int'(pe1), e.pe);
            check_val("u1_brk", int'(brk1), e.brk);
         end
      end
   end

   always @(negedge Clk) begin
      exp_t e;
      if (done2 === 1'b1) begin
         dcnt2++;
         check_val("u2_sb_nonempty", int'(q2.size() > 0), 1);
         if (q2.size() > 0) begin
            e = q2.pop_front();
            check_val("u2_data", int'(data2), e.data);
            check_val("u2_fe", int'(fe2), e.fe);
            check_val("u2_pe", int'(pe2), e.pe);
            check_val("u2_brk", int'(brk2), e.brk);
         end
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic set_line(input int sel, input logic v);
      case (sel)
         0:       rx0 = v;
         1:       rx1 = v;
         default: rx2 = v;
      endcase
   endtask

   task automatic push_exp(input int sel, input int d, input int fe, input int pe, input int brk);
      exp_t e;
      e = '{d, fe, pe, brk};
      case (sel)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   // Drives one frame starting at a falling clock edge; gl_bit >= 0 flips that data bit for one tick mid-bit.
   task automatic send_frame(input int sel, input int data, input int nd, input int npar, input logic pbit,
                             input int nstop, input logic st1, input logic st2, input int bclk, input int gl_bit);
      logic b;
      t_fall = cyc;
      set_line(sel, 1'b0);
      wait_clks(bclk);
      for (int i = 0; i < nd; i++) begin
         b = ((data >> i) & 1) != 0;
         set_line(sel, b);
         if (i == gl_bit) begin
            wait_clks(bclk / 2);
            set_line(sel, !b);
            wait_clks(bclk / 16);
            set_line(sel, b);
            wait_clks(bclk - bclk / 2 - bclk / 16);
         end else begin
            wait_clks(bclk);
         end
      end
      if (npar != 0) begin
         set_line(sel, pbit);
         wait_clks(bclk);
      end
      set_line(sel, st1);
      wait_clks(bclk);
      if (nstop == 2) begin
         set_line(sel, st2);
         wait_clks(bclk);
      end
   endtask

   initial begin
      int snap;
      wait_clks(5);
      check_val("rst_done", int'(done0), 0);
      check_val("rst_data", int'(data0), 0);
      check_val("rst_fe", int'(fe0), 0);
      check_val("rst_pe", int'(pe0), 0);
      check_val("rst_brk", int'(brk0), 0);
      Reset_n = 1'b1;
      wait_clks(5);

      // Basic 8N1 frame and latency
      push_exp(0, 'hA5, 0, 0, 0);
      send_frame(0, 'hA5, 8, 0, 1'b0, 1, 1'b1, 1'b1, BIT0, -1);
      set_line(0, 1'b1);
      wait_clks(2 * BIT0);
      check_val("a5_count", dcnt0, 1);
      check_val("a5_latency", last_done0 - t_fall, 2 + LAT0);
      check_val("a5_hold", int'(data0), 'hA5);

      // Short low glitch on idle line
      set_line(0, 1'b0);
      wait_clks(2 * T0);
      set_line(0, 1'b1);
      wait_clks(11 * BIT0);
      check_val("glitch_count", dcnt0, 1);
      check_val("glitch_data", int'(data0), 'hA5);
      check_val("glitch_fe", int'(fe0), 0);

      // One-tick flip inside data bit 2 is voted out
      push_exp(0, 'h0F, 0, 0, 0);
      send_frame(0, 'h0F, 8, 0, 1'b0, 1, 1'b1, 1'b1, BIT0, 2);
      set_line(0, 1'b1);
      wait_clks(2 * BIT0);
      check_val("flip_count", dcnt0, 2);

      // Break: line low for three frame times, then a short low pulse soon after release
      push_exp(0, 'h00, 1, 0, BRK_EN);
      set_line(0, 1'b0);
      wait_clks(30 * BIT0);
      set_line(0, 1'b1);
      wait_clks(4 * T0);
      if (BRK_EN == 0) push_exp(0, 'hFF, 0, 0, 0);
      set_line(0, 1'b0);
      wait_clks(BIT0);
      set_line(0, 1'b1);
      wait_clks(12 * BIT0);
      check_val("break_count", dcnt0, (BRK_EN != 0) ? 3 : 4);

      // Frame with a bad stop bit, then reset mid-frame
      push_exp(0, 'h81, 1, 0, 0);
      send_frame(0, 'h81, 8, 0, 1'b0, 1, 1'b0, 1'b1, BIT0, -1);
      set_line(0, 1'b1);
      wait_clks(2 * BIT0);
      check_val("fe_hold", int'(fe0), 1);
      snap = dcnt0;
      fork
         send_frame(0, 'hFF, 8, 0, 1'b0, 1, 1'b1, 1'b1, BIT0, -1);
         begin
            wait_clks(5 * BIT0 + BIT0 / 2);
            Reset_n = 1'b0;
            wait_clks(3);
            Reset_n = 1'b1;
         end
      join
      set_line(0, 1'b1);
      wait_clks(2 * BIT0);
      check_val("rst_mid_count", dcnt0, snap);
      check_val("rst_mid_data", int'(data0), 0);
      check_val("rst_mid_fe", int'(fe0), 0);
      push_exp(0, 'h3C, 0, 0, 0);
      send_frame(0, 'h3C, 8, 0, 1'b0, 1, 1'b1, 1'b1, BIT0, -1);
      set_line(0, 1'b1);
      wait_clks(2 * BIT0);
      check_val("after_rst_count", dcnt0, snap + 1);

      // Even parity instance
      push_exp(1, 'h03, 0, 0, 0);
      send_frame(1, 'h03, 8, 1, 1'b0, 1, 1'b1, 1'b1, BITF, -1);
      set_line(1, 1'b1);
      wait_clks(2 * BITF);
      push_exp(1, 'h03, 0, 1, 0);
      send_frame(1, 'h03, 8, 1, 1'b1, 1, 1'b1, 1'b1, BITF, -1);
      set_line(1, 1'b1);
      wait_clks(2 * BITF);
      check_val("par_count", dcnt1, 2);
      check_val("par_hold_pe", int'(pe1), 1);

      // 7 data bits, 2 stop bits: bad second stop, then back-to-back frames
      push_exp(2, 'h55, 1, 0, 0);
      send_frame(2, 'h55, 7, 0, 1'b0, 2, 1'b1, 1'b0, BITF, -1);
      set_line(2, 1'b1);
      wait_clks(2 * BITF);
      push_exp(2, 'h11, 0, 0, 0);
      push_exp(2, 'h22, 0, 0, 0);
      send_frame(2, 'h11, 7, 0, 1'b0, 2, 1'b1, 1'b1, BITF, -1);
      send_frame(2, 'h22, 7, 0, 1'b0, 2, 1'b1, 1'b1, BITF, -1);
      set_line(2, 1'b1);
      wait_clks(3 * BITF);
      check_val("stop2_count", dcnt2, 3);

      check_val("q0_left", q0.size(), 0);
      check_val("q1_left", q1.size(), 0);
      check_val("q2_left", q2.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver that extends the fixed 8N1 byte receiver. It adds configurable data width, parity, 1 or 2 stop bits, 16x oversampling with 3-sample majority voting, and start-bit glitch rejection. It sits between the board RX pin and the command/pixel parser of the TFT display controller. One `Rx_Done` pulse per accepted frame carries data and error flags.

## Interface
- `CLOCK_FREQ`, 50_000_000: system clock in Hz.
- `BAUD`, 115200: line rate.
- `OVERSAMPLE`, 16: ticks per bit; even, ≥ 8.
- `OS_DIV`, CLOCK_FREQ/(BAUD*OVERSAMPLE)-1: prescaler terminal count. Define T = OS_DIV+1 clocks per tick.
- `DATA_BITS`, 8: data width, 5..9, LSB first.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `Clk` input, 1: system clock.
- `Reset_n` input, 1: reset, asynchronous, active-low.
- `uart_rx` input, 1: asynchronous serial line, idle high.
- `Rx_Done` output, 1: one-cycle pulse; frame complete.
- `Rx_Data` output, DATA_BITS: last received word.
- `Frame_Error` output, 1: any stop bit of the last frame sampled 0.
- `Parity_Error` output, 1: parity mismatch in the last frame; always 0 when PARITY=0.
- `Break_Det` output, 1: one-cycle break pulse (see Configuration).

## Operation
- **Synchroniser:** 2-FF chain plus one history register, all async-reset to 1. A falling edge is sync=0 and history=1.
- **FSM states:** IDLE, START, DATA, PAR, STOP, BRK_WAIT.
- **IDLE:** on a falling edge, clear the prescaler and tick counter (`scnt`) and go to START.
- **Ticks:**
  - The prescaler counts 0..OS_DIV; a tick occurs at OS_DIV.
  - `scnt` counts 0..OVERSAMPLE-1 on ticks, then wraps and advances the bit.
- **Sampling:** the line is sampled on ticks with `scnt` = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the majority of the 3 samples, decided on the last of them.
- **START:** a majority of 1 is a glitch; return to IDLE with no outputs changed. Otherwise stay to the end of the bit, then go to DATA.
- **DATA:** shift DATA_BITS bits LSB first, then go to PAR if PARITY≠0, else STOP.
- **PAR:** expected bit = XOR of the data, inverted for odd parity. A mismatch sets the parity-error flag.
- **STOP:**
  - Any stop-bit majority of 0 sets the frame-error flag.
  - With STOP_BITS=2, the first stop bit runs to bit end, then the second is sampled.
  - On the final stop-bit decision: load `Rx_Data`, `Frame_Error` and `Parity_Error`, pulse `Rx_Done` on the next clock, and return to IDLE (or BRK_WAIT). No wait for bit end, which allows back-to-back frames.
- **Held outputs:** `Rx_Data`, `Frame_Error` and `Parity_Error` hold until the next `Rx_Done`. Discarded glitches never touch them.
- **Reset values:** all outputs 0; FSM in IDLE; counters 0. `Reset_n` mid-frame aborts the frame with no `Rx_Done`.
- **Edges while busy:** a falling edge outside IDLE is ignored.

## Timing
- NB = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS.
- `Rx_Done` latency: high exactly ((NB-1)*OVERSAMPLE + OVERSAMPLE/2 + 2)*T + 1 clocks after the cycle in which the falling edge is detected on the synchronised line. The line-to-detect delay is 2 clocks.
- `Rx_Data` and the flags are valid in the same cycle as `Rx_Done` and after it.
- Glitch rejection: a low pulse shorter than (OVERSAMPLE/2-1)*T clocks produces no frame.
- Baud error tolerance: ±3% total, guaranteed by the parameter choice, not checked in RTL.

## Configuration
- Macro: `UART_RX_BREAK_DET_EN`.
- **Defined:** break detection is compiled in.
  - A frame with all data bits 0, parity bit 0 (if present) and first stop bit 0 is a break.
  - It pulses `Break_Det` together with `Rx_Done`, with `Frame_Error`=1.
  - The FSM then enters BRK_WAIT and stays until the synchronised line is 1 for OVERSAMPLE consecutive ticks, then returns to IDLE.
- **Undefined:** `Break_Det` is tied to 0 and BRK_WAIT does not exist. A break reports as a zero frame with `Frame_Error`=1 and re-arms in IDLE immediately.

## Test plan
All scenarios use defaults (8N1, 50 MHz, 115200) unless noted.
- Send 0xA5 → one `Rx_Done`, `Rx_Data`=0xA5, both error flags 0, at the latency given in Timing.
- PARITY=2: send 0x03 with parity bit 0 → `Parity_Error`=0. Send 0x03 with parity bit 1 → `Parity_Error`=1, `Rx_Data`=0x03.
- STOP_BITS=2, DATA_BITS=7: send 0x55 with the second stop bit 0 → `Frame_Error`=1, `Rx_Data`=0x55. Then send back-to-back 0x11, 0x22 → two pulses with correct data.
- 2×T-clock low glitch on an idle line → no `Rx_Done`, outputs unchanged. A single-tick flip inside a data bit is voted out: 0x0F is received intact.
- Line held low for 3 frame times, then released:
  - With the macro: one `Rx_Done` with `Rx_Data`=0x00, `Frame_Error`=1 and `Break_Det`=1, then no frames until 16 idle ticks.
  - Without the macro: the same frame with `Break_Det`=0.
- `Reset_n` asserted at data bit 4 of 0xFF, then released → all outputs 0, no `Rx_Done`. The next frame 0x3C is received correctly.
